// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encodings, the counter
// update function and the per-entry metadata record.
package bp_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  localparam ctr_e CtrReset = CtrWnt;

  // Tag and target widths depend on XLEN/BTB_DEPTH, so they live in bp_btb
  // arrays next to this record rather than inside it.
  typedef struct packed {
    logic valid;
    ctr_e ctr;
  } btb_meta_t;

  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
    ctr_e nxt;
    unique case (ctr)
      CtrSnt:  nxt = taken ? CtrWnt : CtrSnt;
      CtrWnt:  nxt = taken ? CtrWt  : CtrSnt;
      CtrWt:   nxt = taken ? CtrSt  : CtrWnt;
      default: nxt = taken ? CtrSt  : CtrWt;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational lookup port and one
// update port. Addresses are word addresses (pc[XLEN-1:2]).
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned BTB_DEPTH  = 16,
  parameter bit          PREDICT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] lookup_waddr,
  output logic            lookup_taken,
  output logic [XLEN-1:0] lookup_target,
  input  logic            upd_valid,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic [XLEN-3:0] upd_waddr,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned IdxW = $clog2(BTB_DEPTH);
  localparam int unsigned TagW = XLEN - 2 - IdxW;

  btb_meta_t       meta_q   [BTB_DEPTH];
  logic [TagW-1:0] tag_q    [BTB_DEPTH];
  logic [XLEN-1:0] target_q [BTB_DEPTH];

  logic [IdxW-1:0] lk_idx, up_idx;
  logic [TagW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit;

  assign lk_idx = lookup_waddr[IdxW-1:0];
  assign lk_tag = lookup_waddr[XLEN-3:IdxW];
  assign up_idx = upd_waddr[IdxW-1:0];
  assign up_tag = upd_waddr[XLEN-3:IdxW];

  assign lk_hit        = PREDICT_EN && meta_q[lk_idx].valid && (tag_q[lk_idx] == lk_tag);
  assign lookup_taken  = lk_hit && meta_q[lk_idx].ctr[1];
  assign lookup_target = target_q[lk_idx];

  // Training ignores PREDICT_EN so the table state stays meaningful either way.
  assign up_hit = meta_q[up_idx].valid && (tag_q[up_idx] == up_tag);

  logic            upd_we;
  btb_meta_t       upd_meta;
  logic [XLEN-1:0] upd_tgt;

  always_comb begin
    upd_we   = 1'b0;
    upd_meta = meta_q[up_idx];
    upd_tgt  = target_q[up_idx];
    if (upd_valid) begin
      if (up_hit) begin
        upd_we       = 1'b1;
        upd_meta.ctr = upd_is_jump ? CtrSt : ctr_next(meta_q[up_idx].ctr, upd_taken);
        if (upd_taken) upd_tgt = upd_target;
      end else if (upd_taken) begin
        upd_we         = 1'b1;
        upd_meta.valid = 1'b1;
        upd_meta.ctr   = upd_is_jump ? CtrSt : CtrWt;
        upd_tgt        = upd_target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        meta_q[i]   <= '{valid: 1'b0, ctr: CtrReset};
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (upd_we) begin
      meta_q[up_idx]   <= upd_meta;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_tgt;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based prediction, D-stage JAL and EX-stage
// mispredict redirects, and the next-PC priority mux.
module pc_predict_unit
  import bp_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     BTB_DEPTH  = 16,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter bit              PREDICT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  output logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            jal_d,
  input  logic [XLEN-1:0] jal_target_d,
  input  logic            pred_taken_d,
  input  logic [XLEN-1:0] pred_target_d,
  input  logic            ex_valid,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            pred_taken_e,
  input  logic [XLEN-1:0] pred_target_e,
  output logic            redirect_e,
  output logic            redirect_d
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] btb_target;
  logic            btb_taken;

  bp_btb #(
    .XLEN      (XLEN),
    .BTB_DEPTH (BTB_DEPTH),
    .PREDICT_EN(PREDICT_EN)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_waddr (pc_q[XLEN-1:2]),
    .lookup_taken (btb_taken),
    .lookup_target(btb_target),
    .upd_valid    (ex_valid),
    .upd_taken    (ex_taken),
    .upd_is_jump  (ex_is_jump),
    .upd_waddr    (ex_pc[XLEN-1:2]),
    .upd_target   (ex_target)
  );

  assign pc_f          = pc_q;
  assign pred_taken_f  = btb_taken;
  assign pred_target_f = btb_taken ? btb_target : pc_q + XLEN'(4);

  assign redirect_e = ex_valid &&
                      ((ex_taken != pred_taken_e) || (ex_taken && (ex_target != pred_target_e)));
  // A JAL already predicted to the right target needs no D-stage redirect.
  assign redirect_d = jal_d && !redirect_e && !(pred_taken_d && (pred_target_d == jal_target_d));

  always_comb begin
    pc_d = pred_target_f;
    if (redirect_e)      pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
    else if (redirect_d) pc_d = jal_target_d;
    else if (stall_f)    pc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit: a vector table of stimulus and
// expected outputs, with next-PC expectations queued and checked after the edge.
module tb_pc_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, jal_d, pred_taken_d, ex_valid, ex_is_jump, ex_taken, pred_taken_e;
  logic [31:0] jal_target_d, pred_target_d, ex_pc, ex_target, pred_target_e;
  logic [31:0] pc_f, pred_target_f, np_pc_f, np_pred_target_f;
  logic        pred_taken_f, redirect_e, redirect_d;
  logic        np_pred_taken_f, np_redirect_e, np_redirect_d;

  always #5 clk = ~clk;

  pc_predict_unit #(
    .XLEN(32), .BTB_DEPTH(4), .RESET_PC(32'h100), .PREDICT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .pc_f(pc_f),
    .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
    .jal_d(jal_d), .jal_target_d(jal_target_d),
    .pred_taken_d(pred_taken_d), .pred_target_d(pred_target_d),
    .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .pred_taken_e(pred_taken_e), .pred_target_e(pred_target_e),
    .redirect_e(redirect_e), .redirect_d(redirect_d)
  );

  // Static not-taken variant; its own pipeline never carries a prediction.
  pc_predict_unit #(
    .XLEN(32), .BTB_DEPTH(4), .RESET_PC(32'h100), .PREDICT_EN(1'b0)
  ) dut_np (
    .clk(clk), .rst(rst), .stall_f(stall_f), .pc_f(np_pc_f),
    .pred_taken_f(np_pred_taken_f), .pred_target_f(np_pred_target_f),
    .jal_d(jal_d), .jal_target_d(jal_target_d),
    .pred_taken_d(1'b0), .pred_target_d(32'h0),
    .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .pred_taken_e(1'b0), .pred_target_e(32'h0),
    .redirect_e(np_redirect_e), .redirect_d(np_redirect_d)
  );

  typedef struct {
    logic        stall, jal;
    logic [31:0] jt;
    logic        pd;
    logic [31:0] pdt;
    logic        xv, xj;
    logic [31:0] xpc;
    logic        xt;
    logic [31:0] xtg;
    logic        pe;
    logic [31:0] pet;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptg;
    logic        e_re, e_rd;
    logic [31:0] e_next;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[$];
  logic [31:0] sb[$];

  function automatic vec_t mk(
    input logic s, j, input logic [31:0] jt, input logic pd, input logic [31:0] pdt,
    input logic xv, xj, input logic [31:0] xpc, input logic xt, input logic [31:0] xtg,
    input logic pe, input logic [31:0] pet,
    input logic [31:0] epc, input logic ept, input logic [31:0] eptg,
    input logic ere, erd, input logic [31:0] enx);
    vec_t v;
    v.stall = s;  v.jal = j;  v.jt = jt;  v.pd = pd;  v.pdt = pdt;
    v.xv = xv;  v.xj = xj;  v.xpc = xpc;  v.xt = xt;  v.xtg = xtg;
    v.pe = pe;  v.pet = pet;
    v.e_pc = epc;  v.e_pt = ept;  v.e_ptg = eptg;
    v.e_re = ere;  v.e_rd = erd;  v.e_next = enx;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                                input logic [31:0] nx);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc, pt, ptg, 0, 0, nx);
  endfunction

  function automatic vec_t jal(input logic [31:0] tgt, input logic [31:0] pc, input logic pt,
                               input logic [31:0] ptg);
    return mk(0, 1, tgt, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc, pt, ptg, 0, 1, tgt);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    stall_f = 0;  jal_d = 0;  jal_target_d = 0;  pred_taken_d = 0;  pred_target_d = 0;
    ex_valid = 0;  ex_is_jump = 0;  ex_pc = 0;  ex_taken = 0;  ex_target = 0;
    pred_taken_e = 0;  pred_target_e = 0;
  endtask

  // Called just after a negedge; returns at the following negedge.
  task automatic step(input vec_t t, input string nm);
    logic [31:0] exp_pc;
    stall_f = t.stall;  jal_d = t.jal;  jal_target_d = t.jt;
    pred_taken_d = t.pd;  pred_target_d = t.pdt;
    ex_valid = t.xv;  ex_is_jump = t.xj;  ex_pc = t.xpc;  ex_taken = t.xt;
    ex_target = t.xtg;  pred_taken_e = t.pe;  pred_target_e = t.pet;
    #1;
    chk({nm, "_pc"}, pc_f, t.e_pc);
    chk({nm, "_ptaken"}, 32'(pred_taken_f), 32'(t.e_pt));
    chk({nm, "_ptarget"}, pred_target_f, t.e_ptg);
    chk({nm, "_redir_e"}, 32'(redirect_e), 32'(t.e_re));
    chk({nm, "_redir_d"}, 32'(redirect_d), 32'(t.e_rd));
    chk({nm, "_np_ptaken"}, 32'(np_pred_taken_f), 32'h0);
    chk({nm, "_np_redir_e"}, 32'(np_redirect_e), 32'(t.xv && t.xt));
    sb.push_back(t.e_next);
    @(posedge clk);
    #1;
    exp_pc = sb.pop_front();
    chk({nm, "_next_pc"}, pc_f, exp_pc);
    @(negedge clk);
  endtask

  initial begin
    // Branch 0x200->0x300, train down, JAL/stall/priority, aliasing at
    // index 0 (0x10 vs 0x20), jump allocation, target retrain, PC wrap.
    tbl.push_back(idle(32'h100, 0, 32'h104, 32'h104));
    tbl.push_back(idle(32'h104, 0, 32'h108, 32'h108));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h200, 1, 32'h300, 0, 32'h204,
                     32'h108, 0, 32'h10c, 1, 0, 32'h300));
    tbl.push_back(jal(32'h200, 32'h300, 0, 32'h304));
    tbl.push_back(idle(32'h200, 1, 32'h300, 32'h300));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 32'h0, 1, 32'h300,
                     32'h300, 0, 32'h304, 1, 0, 32'h204));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 32'h0, 0, 32'h204,
                     32'h204, 0, 32'h208, 0, 0, 32'h208));
    tbl.push_back(jal(32'h200, 32'h208, 0, 32'h20c));
    tbl.push_back(idle(32'h200, 0, 32'h204, 32'h204));
    tbl.push_back(mk(1, 1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     32'h204, 0, 32'h208, 0, 1, 32'h400));
    tbl.push_back(mk(1, 1, 32'h500, 0, 0, 1, 0, 32'h600, 1, 32'h700, 0, 0,
                     32'h400, 0, 32'h404, 1, 0, 32'h700));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     32'h700, 0, 32'h704, 0, 0, 32'h700));
    tbl.push_back(mk(0, 1, 32'h800, 1, 32'h800, 0, 0, 0, 0, 0, 0, 0,
                     32'h700, 0, 32'h704, 0, 0, 32'h704));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h10, 1, 32'h80, 0, 0,
                     32'h704, 0, 32'h708, 1, 0, 32'h80));
    tbl.push_back(jal(32'h10, 32'h80, 0, 32'h84));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h20, 1, 32'h90, 0, 0,
                     32'h10, 1, 32'h80, 1, 0, 32'h90));
    tbl.push_back(jal(32'h10, 32'h90, 0, 32'h94));
    tbl.push_back(idle(32'h10, 0, 32'h14, 32'h14));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h14, 1, 32'h40, 0, 0,
                     32'h14, 0, 32'h18, 1, 0, 32'h40));
    tbl.push_back(jal(32'h14, 32'h40, 0, 32'h44));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h14, 0, 32'h0, 1, 32'h40,
                     32'h14, 1, 32'h40, 1, 0, 32'h18));
    tbl.push_back(jal(32'h14, 32'h18, 0, 32'h1c));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h14, 1, 32'h44, 1, 32'h40,
                     32'h14, 1, 32'h40, 1, 0, 32'h44));
    tbl.push_back(jal(32'h14, 32'h44, 0, 32'h48));
    tbl.push_back(idle(32'h14, 1, 32'h44, 32'h44));
    tbl.push_back(jal(32'hffff_fffc, 32'h44, 0, 32'h48));
    tbl.push_back(idle(32'hffff_fffc, 0, 32'h0, 32'h0));

    rst = 1'b1;
    drive_idle();
    #1;
    chk("reset_pc", pc_f, 32'h100);
    chk("reset_ptaken", 32'(pred_taken_f), 32'h0);
    chk("reset_ptarget", pred_target_f, 32'h104);
    chk("reset_np_pc", np_pc_f, 32'h100);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("v%0d", i));

    // Asynchronous reset mid-run must clear the PC at once and empty the BTB.
    #2 rst = 1'b1;
    #1;
    chk("midrst_pc", pc_f, 32'h100);
    chk("midrst_ptarget", pred_target_f, 32'h104);
    @(negedge clk);
    rst = 1'b0;
    step(jal(32'h14, 32'h100, 0, 32'h104), "post_rst_jal");
    step(idle(32'h14, 0, 32'h18, 32'h18), "post_rst_miss");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
